mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store front end between the CPU execute stage and datamem. Accepts one
//  request at a time over a valid/ready handshake and checks alignment and range.
//  Drives datamem's address/datain/WE/writebyte/writehalfword ports and waits a
//  programmable number of cycles. Returns sign/zero-extended load data or a fault
//  code over a second valid/ready handshake.
// PARAMETERS
//  STARTADDR   32'h1000_0000  first byte address of datamem
//  LENGTH      32'h0000_1000  datamem size in bytes (multiple of 4)
//  WAIT_CYCLES 1              cycles in ACCESS per request (legal 1..255)
// PORTS
//  clk                in   1   clock, all state on posedge
//  rst_n              in   1   synchronous active-low reset
//  req_valid          in   1   request present
//  req_ready          out  1   unit can accept (high only in IDLE)
//  req_op             in   3   0 LB,1 LH,2 LW,3 SB,4 LBU,5 LHU,6 SH,7 SW
//  req_addr           in   32  byte address
//  req_wdata          in   32  store data (right-justified)
//  mem_address        out  32  to datamem address
//  mem_datain         out  32  to datamem datain
//  mem_we             out  1   to datamem WE
//  mem_writebyte      out  1   to datamem writebyte
//  mem_writehalfword  out  1   to datamem writehalfword
//  mem_data           in   32  from datamem data (async read)
//  rsp_valid          out  1   response present
//  rsp_ready          in   1   consumer accepts response
//  rsp_rdata          out  32  load result; 0 for stores and faults
//  rsp_fault          out  2   00 ok, 01 misaligned, 10 out of range
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state IDLE, counter 0, and all latched
//    op/addr/wdata/rdata/fault cleared. Every output is 0 while rst_n=0; this
//    includes req_ready. A reset in any state aborts the request with no
//    response.
//  - FSM states: IDLE, ACCESS, RESP.
//  - IDLE: req_ready=1. On req_valid, latch op/addr/wdata and compute fault.
//    - fault!=0 -> RESP, with no memory access.
//    - fault=0  -> ACCESS, with counter=WAIT_CYCLES-1.
//  - Fault check:
//    - misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. This has
//      priority over range.
//    - range: addr<STARTADDR or addr>=STARTADDR+LENGTH. Compare in 33 bits so
//      there is no wrap at 32'hFFFF_FFFF.
//  - ACCESS: mem_address=latched addr and mem_datain=latched wdata, held for the
//    whole state.
//    - writebyte=1 for SB; writehalfword=1 for SH; both 0 otherwise.
//    - Counter decrements each cycle. Final cycle is counter==0.
//    - Store: mem_we=1 only in the final cycle. It is combinational from
//      state/op/counter and gated by rst_n, so exactly one datamem write edge
//      occurs and a reset at that edge suppresses the write.
//    - Load: mem_we=0. At the final edge, capture mem_data (big-endian):
//      LB  sext(mem_data[31:24]); LBU zext(mem_data[31:24]);
//      LH  sext(mem_data[31:16]); LHU zext(mem_data[31:16]); LW mem_data.
//    - Final cycle -> RESP.
//  - Outside ACCESS: mem_we, writebyte and writehalfword are 0. mem_address and
//    mem_datain hold the last latched values.
//  - RESP: rsp_valid=1, with rdata/fault stable until the cycle rsp_ready=1,
//    then IDLE. req_valid is ignored in RESP; there is no same-cycle re-accept.
//  - Latency from the accept edge: ok rsp_valid rises WAIT_CYCLES+1 cycles later;
//    fault rsp_valid rises 1 cycle later.
// TESTING
//  1. Hold rst_n=0 for 3 cycles -> all outputs 0; after release req_ready=1 and
//     mem_we never pulsed.
//  2. SW 32'hDEADBEEF @32'h1000_0010, then LW same address -> mem_we high exactly
//     1 cycle; rsp_rdata=32'hDEADBEEF, rsp_fault=00.
//  3. From the same word, loads return:
//     LB 32'hFFFF_FFDE; LBU 32'h0000_00DE; LH 32'hFFFF_DEAD; LHU 32'h0000_DEAD.
//  4. Fault codes, each with no mem_we and rsp_valid 1 cycle after accept:
//     SH @32'h1000_0011 -> 01;  LW @32'h1000_1000 -> 10;
//     LW @32'h0FFF_FFFC -> 10;  LW @32'hFFFF_FFFC -> 10.
//  5. rsp_ready=0 for 5 cycles after a load -> rsp_valid, rsp_rdata and
//     rsp_fault stable and req_ready=0. A new req_valid is not accepted until
//     after rsp_ready.
//  6. WAIT_CYCLES=3: SW 32'h1234_5678 @32'h1000_0020, with rst_n=0 in the 2nd
//     ACCESS cycle -> no write; a later LW returns the prior contents.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Load/store front end between the CPU execute stage and the data memory.
// One request is accepted at a time over a valid/ready handshake. The unit
// checks the request for alignment and range, drives the datamem port for a
// programmable number of cycles, and returns extended load data or a fault
// code over a second valid/ready handshake.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_op/req_addr/req_wdata  operation, byte address, right-justified data
//   mem_address/mem_datain     datamem address and write data
//   mem_we                     datamem write enable (one cycle per store)
//   mem_writebyte/halfword     datamem store width selects
//   mem_data                   datamem asynchronous read data
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata/rsp_fault        load result / fault code (00 ok, 01 misaligned,
//                              10 out of range)
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter logic [31:0] STARTADDR   = 32'h1000_0000,
    parameter logic [31:0] LENGTH      = 32'h0000_1000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_datain,
    output logic        mem_we,
    output logic        mem_writebyte,
    output logic        mem_writehalfword,
    input  logic [31:0] mem_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_fault
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_SB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_LHU = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    // Bounds kept in 33 bits so a window ending at the top of the address
    // space cannot wrap around to zero.
    localparam logic [32:0] LO_BOUND  = {1'b0, STARTADDR};
    localparam logic [32:0] HI_BOUND  = {1'b0, STARTADDR} + {1'b0, LENGTH};
    localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYCLES - 1);

    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_half(input logic [2:0] op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_word(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // Misalignment takes priority over the range check.
    function automatic logic [1:0] check_fault(input logic [2:0] op, input logic [31:0] addr);
        logic [32:0] a33;
        logic [1:0]  f;
        a33 = {1'b0, addr};
        if ((is_half(op) && addr[0]) || (is_word(op) && (addr[1:0] != 2'b00))) begin
            f = FAULT_MISALIGN;
        end else if ((a33 < LO_BOUND) || (a33 >= HI_BOUND)) begin
            f = FAULT_RANGE;
        end else begin
            f = FAULT_OK;
        end
        return f;
    endfunction

    // Datamem returns the addressed byte in the top lane (big-endian).
    function automatic logic [31:0] extend_load(input logic [2:0] op, input logic [31:0] d);
        logic [31:0] r;
        case (op)
            OP_LB:   r = {{24{d[31]}}, d[31:24]};
            OP_LBU:  r = {24'h00_0000, d[31:24]};
            OP_LH:   r = {{16{d[31]}}, d[31:16]};
            OP_LHU:  r = {16'h0000, d[31:16]};
            OP_LW:   r = d;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  fault_q, fault_d;
    logic [1:0]  req_fault_s;
    logic        in_access_s;
    logic        last_cycle_s;

    assign req_fault_s  = check_fault(req_op, req_addr);
    assign in_access_s  = rst_n && (state_q == ST_ACCESS);
    assign last_cycle_s = (cnt_q == 8'd0);

    // Next-state and datapath update for the request/access/response sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 32'h0000_0000;
                    fault_d = req_fault_s;
                    if (req_fault_s != FAULT_OK) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ACCESS;
                        cnt_d   = WAIT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (last_cycle_s) begin
                    if (!is_store(op_q)) begin
                        rdata_d = extend_load(op_q, mem_data);
                    end else begin
                        rdata_d = 32'h0000_0000;
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            op_q    <= 3'd0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            fault_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Outputs decode registered state; gating with rst_n forces them low for
    // the whole reset, and kills a store write strobe on the reset edge.
    always_comb begin
        if (rst_n) begin
            req_ready         = (state_q == ST_IDLE);
            mem_address       = addr_q;
            mem_datain        = wdata_q;
            mem_we            = in_access_s && is_store(op_q) && last_cycle_s;
            mem_writebyte     = in_access_s && (op_q == OP_SB);
            mem_writehalfword = in_access_s && (op_q == OP_SH);
            rsp_valid         = (state_q == ST_RESP);
            rsp_rdata         = rdata_q;
            rsp_fault         = fault_q;
        end else begin
            req_ready         = 1'b0;
            mem_address       = 32'h0000_0000;
            mem_datain        = 32'h0000_0000;
            mem_we            = 1'b0;
            mem_writebyte     = 1'b0;
            mem_writehalfword = 1'b0;
            rsp_valid         = 1'b0;
            rsp_rdata         = 32'h0000_0000;
            rsp_fault         = 2'b00;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Scoreboard bench for mem_access_unit. A byte-array datamem model sits on the
// memory port; a separate byte-array reference model predicts every response.
// The driver pushes expectations when it issues a request, a monitor pops and
// compares whenever a response is presented or handed over.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam logic [31:0] START = 32'h1000_0000;
    localparam logic [31:0] LEN   = 32'h0000_1000;
    localparam int          WC    = 3;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem_address;
    logic [31:0] mem_datain;
    logic        mem_we;
    logic        mem_writebyte;
    logic        mem_writehalfword;
    logic [31:0] mem_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_fault;

    mem_access_unit #(
        .STARTADDR   (START),
        .LENGTH      (LEN),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_op            (req_op),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .mem_address       (mem_address),
        .mem_datain        (mem_datain),
        .mem_we            (mem_we),
        .mem_writebyte     (mem_writebyte),
        .mem_writehalfword (mem_writehalfword),
        .mem_data          (mem_data),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_rdata         (rsp_rdata),
        .rsp_fault         (rsp_fault)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  fault;
        int          we_total;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   acc_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_count = 0;
    int exp_we_total = 0;
    int stall_n = 0;
    int stall_used = 0;

    byte unsigned dm [4096];
    byte unsigned ref_mem [4096];
    logic [31:0]  dm_off;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // datamem model: asynchronous big-endian read, write on posedge with WE
    always_comb begin
        dm_off = mem_address - START;
        if ((mem_address >= START) && (dm_off < LEN)) begin
            mem_data = {dm[dm_off[11:0]], dm[dm_off[11:0] + 12'd1],
                        dm[dm_off[11:0] + 12'd2], dm[dm_off[11:0] + 12'd3]};
        end else begin
            mem_data = 32'h0000_0000;
        end
    end

    always @(posedge clk) begin
        if (mem_we && (mem_address >= START) && (dm_off < LEN)) begin
            if (mem_writebyte) begin
                dm[dm_off[11:0]] <= mem_datain[7:0];
            end else if (mem_writehalfword) begin
                dm[dm_off[11:0]]         <= mem_datain[15:8];
                dm[dm_off[11:0] + 12'd1] <= mem_datain[7:0];
            end else begin
                dm[dm_off[11:0]]         <= mem_datain[31:24];
                dm[dm_off[11:0] + 12'd1] <= mem_datain[23:16];
                dm[dm_off[11:0] + 12'd2] <= mem_datain[15:8];
                dm[dm_off[11:0] + 12'd3] <= mem_datain[7:0];
            end
        end
    end

    // cycle count, write-strobe count and accept-edge log
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) we_count <= we_count + 1;
        if (rst_n && req_valid && req_ready) acc_q.push_back(cyc);
    end

    // consumer: random back-pressure, with forced stalls when requested
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_valid && (stall_used < stall_n)) begin
                rsp_ready = 1'b0;
                stall_used++;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // monitor
    logic        pend = 1'b0;
    logic [31:0] hold_rdata;
    logic [1:0]  hold_fault;
    int          acc_edge;
    exp_t        got_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else if (rsp_valid) begin
            if (!pend) begin
                if ((acc_q.size() == 0) || (sb_q.size() == 0)) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    acc_edge = acc_q.pop_front();
                    chk("latency", 32'(cyc - acc_edge), 32'(sb_q[0].lat));
                end
                hold_rdata = rsp_rdata;
                hold_fault = rsp_fault;
            end else begin
                chk("rdata_stable", rsp_rdata, hold_rdata);
                chk("fault_stable", 32'(rsp_fault), 32'(hold_fault));
            end
            chk("req_ready_in_resp", 32'(req_ready), 32'd0);
            if (rsp_ready) begin
                if (sb_q.size() > 0) begin
                    got_e = sb_q.pop_front();
                    chk("rdata", rsp_rdata, got_e.rdata);
                    chk("fault", 32'(rsp_fault), 32'(got_e.fault));
                    chk("we_count", 32'(we_count), 32'(got_e.we_total));
                end
                pend = 1'b0;
            end else begin
                pend = 1'b1;
            end
        end else begin
            pend = 1'b0;
        end
    end

    // Reference model: predict the response and update model memory.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        longint      a;
        int unsigned off;
        int          b0, b1, h;
        bit          halfop, wordop, store;
        bit          ok;
        a      = longint'(addr);
        halfop = (op == 3'd1) || (op == 3'd5) || (op == 3'd6);
        wordop = (op == 3'd2) || (op == 3'd7);
        store  = (op == 3'd3) || (op == 3'd6) || (op == 3'd7);
        e.rdata = 32'd0;
        if ((halfop && (addr % 2 != 0)) || (wordop && (addr % 4 != 0))) begin
            e.fault = 2'b01;
        end else if ((a < longint'(START)) || (a >= longint'(START) + longint'(LEN))) begin
            e.fault = 2'b10;
        end else begin
            e.fault = 2'b00;
            off = addr - START;
            if (store) begin
                exp_we_total++;
                if (op == 3'd3) begin
                    ref_mem[off] = wdata[7:0];
                end else if (op == 3'd6) begin
                    ref_mem[off]     = wdata[15:8];
                    ref_mem[off + 1] = wdata[7:0];
                end else begin
                    ref_mem[off]     = wdata[31:24];
                    ref_mem[off + 1] = wdata[23:16];
                    ref_mem[off + 2] = wdata[15:8];
                    ref_mem[off + 3] = wdata[7:0];
                end
            end else begin
                b0 = ref_mem[off];
                b1 = ref_mem[(off + 1) % 4096];
                h  = b0 * 256 + b1;
                case (op)
                    3'd0: e.rdata = 32'((b0 >= 128) ? b0 - 256 : b0);
                    3'd4: e.rdata = 32'(b0);
                    3'd1: e.rdata = 32'((h >= 32768) ? h - 65536 : h);
                    3'd5: e.rdata = 32'(h);
                    default: e.rdata = {ref_mem[off], ref_mem[off + 1],
                                        ref_mem[off + 2], ref_mem[off + 3]};
                endcase
            end
        end
        e.lat      = (e.fault == 2'b00) ? WC + 1 : 1;
        e.we_total = exp_we_total;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; (i < 1000) && (sb_q.size() > 0); i++) @(posedge clk);
        chk("drain_pending", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] addr;
        int          r;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;

        // reset: all outputs low for three cycles
        repeat (3) begin
            @(negedge clk);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_mem_ctl", {29'd0, mem_we, mem_writebyte, mem_writehalfword}, 32'd0);
            chk("rst_mem_address", mem_address, 32'd0);
            chk("rst_mem_datain", mem_datain, 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
            chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        chk("post_rst_we_count", 32'(we_count), 32'd0);

        // store/load round trip and extensions
        issue(3'd7, 32'h1000_0010, 32'hDEAD_BEEF);
        issue(3'd2, 32'h1000_0010, 32'd0);
        issue(3'd0, 32'h1000_0010, 32'd0);
        issue(3'd4, 32'h1000_0010, 32'd0);
        issue(3'd1, 32'h1000_0010, 32'd0);
        issue(3'd5, 32'h1000_0010, 32'd0);
        issue(3'd3, 32'h1000_0013, 32'h0000_00A5);
        issue(3'd6, 32'h1000_0014, 32'h0000_8123);
        issue(3'd2, 32'h1000_0010, 32'd0);
        issue(3'd2, 32'h1000_0014, 32'd0);

        // faults
        issue(3'd6, 32'h1000_0011, 32'h1111_1111);
        issue(3'd2, 32'h1000_1000, 32'd0);
        issue(3'd2, 32'h0FFF_FFFC, 32'd0);
        issue(3'd2, 32'hFFFF_FFFC, 32'd0);
        issue(3'd0, 32'h1000_0FFF, 32'd0);
        drain();

        // held response: consumer stalls five cycles
        stall_n = stall_n + 5;
        issue(3'd2, 32'h1000_0010, 32'd0);
        issue(3'd1, 32'h1000_0012, 32'd0);
        drain();
        chk("stall_consumed", 32'(stall_used), 32'(stall_n));

        // reset during the second access cycle of a store aborts the write
        issue(3'd7, 32'h1000_0020, 32'hCAFE_F00D);
        drain();
        @(posedge clk);
        #1;
        req_op    = 3'd7;
        req_addr  = 32'h1000_0020;
        req_wdata = 32'h1234_5678;
        req_valid = 1'b1;
        for (int i = 0; (i < 50) && !req_ready; i++) @(negedge clk);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        acc_q.delete();
        repeat (4) @(posedge clk);
        chk("abort_no_write", 32'(we_count), 32'(exp_we_total));
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        issue(3'd2, 32'h1000_0020, 32'd0);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            op = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 9);
            if (r < 7) begin
                addr = START + 32'($urandom_range(0, 63));
            end else if (r < 9) begin
                addr = START + LEN - 32'd8 + 32'($urandom_range(0, 15));
            end else begin
                addr = $urandom();
            end
            issue(op, addr, $urandom());
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
